fetch_queue: RTL and testbench

- Instruction-fetch stage directly upstream of the ARM core's instruction input. It replaces the zero-latency combinational instruction-memory read with a pipelined request/response memory port.
- Fetches sequentially from its own fetch PC into a small prefetch queue, and presents {instr, pc} to the core with a valid/ready handshake.
- A redirect input (taken branch or write to PC) flushes the queue and discards in-flight responses.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_queue.sv | 103 ++++++++++
 tb/tb_fetch_queue.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch queue.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam int          ENTRY_W = $bits(fetch_entry_t);
    localparam logic [31:0] PC_STEP = 32'd4;

    // Counters must be able to hold the value DEPTH itself, not just DEPTH-1.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry prefetch FIFO of {instr, pc} entries with synchronous flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = cnt_width(DEPTH),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_data_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output logic [CW-1:0]      count_o,
    output logic [ENTRY_W-1:0] head_o
);

    logic [DEPTH-1:0][ENTRY_W-1:0] mem_q;
    logic [PW-1:0]                 rd_q;
    logic [PW-1:0]                 wr_q;
    logic [CW-1:0]                 cnt_q;

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            mem_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= wr_q + PW'(1);
            end
            if (pop_i) begin
                rd_q <= rd_q + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fetch_queue.sv
// Sequential instruction prefetcher: pipelined memory port in, {instr, pc}
// valid/ready stream out, with redirect flushing queue and in-flight data.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data
);

    localparam int CW = cnt_width(DEPTH);
    localparam int SW = CW + 2;

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] live_q, live_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] occ;
    logic [SW-1:0] pending;
    logic          req_fire, rsp_keep, rsp_drop, push, pop;
    logic [31:0]   redirect_pc_w;
    fetch_entry_t  push_entry, head;

    assign redirect_pc_w = {redirect_pc[31:2], 2'b00};

    // Credit covers queued entries plus every response still owed to us,
    // so an accepted request always has a slot waiting for it.
    assign pending       = SW'(occ) + SW'(live_q) + SW'(drop_q);
    assign mem_req_valid = reset && !redirect && (pending < SW'(DEPTH));
    assign mem_req_addr  = fetch_pc_q;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign rsp_drop = mem_rsp_valid && (drop_q != '0);
    assign rsp_keep = mem_rsp_valid && (drop_q == '0) && (live_q != '0);

    assign push             = rsp_keep && !redirect;
    assign push_entry.instr = mem_rsp_data;
    assign push_entry.pc    = rsp_pc_q;

    assign instr_valid = reset && !redirect && (occ != '0);
    assign pop         = instr_valid && instr_ready;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk),
        .reset_i     (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect),
        .count_o     (occ),
        .head_o      (head)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        live_d     = live_q;
        drop_d     = drop_q;
        if (redirect) begin
            // Everything still outstanding becomes garbage; a response landing
            // this very cycle is already consumed and discarded.
            fetch_pc_d = redirect_pc_w;
            rsp_pc_d   = redirect_pc_w;
            live_d     = '0;
            drop_d     = live_q + drop_q - CW'(rsp_keep || rsp_drop);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
            if (rsp_keep) rsp_pc_d   = rsp_pc_q + PC_STEP;
            live_d = live_q + CW'(req_fire) - CW'(rsp_keep);
            if (rsp_drop) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            live_q     <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            live_q     <= live_d;
            drop_q     <= drop_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: cycle tables plus redirect/wrap/reset sequences.
module tb_fetch_queue;

    localparam logic [31:0] KEY = 32'hC0DE_F00D;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_before;
        logic        redir;
        logic [31:0] rpc;
        logic        irdy;
        logic        mrdy;
        logic        ereq;
        logic [31:0] eaddr;
        logic        eiv;
        logic [31:0] epc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    vec_t        tbl[$];
    mreq_t       mq[$];
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          lat     = 1;
    int          inflight = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] at(input logic [31:0] q[$], input int k);
        if (k < q.size()) return q[k];
        return 32'hBAD0_BAD0;
    endfunction

    // One clock: sample handshakes at negedge, then model the memory after the edge.
    task automatic tick();
        logic rst_now;
        @(negedge clk);
        rst_now = reset;
        if (mem_rsp_valid) begin
            assert (inflight > 0) else $error("memory response with nothing outstanding");
            inflight--;
        end
        if (reset && mem_req_valid && mem_req_ready) begin
            mq.push_back('{addr: mem_req_addr, due: cyc + lat});
            acc_log.push_back(mem_req_addr);
            inflight++;
        end
        if (reset && instr_valid && instr_ready) begin
            pop_log.push_back(instr_pc);
            check("pop_data", instr, instr_pc ^ KEY);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_now) begin
            mq.delete();
            inflight = 0;
        end
        if (mq.size() != 0 && mq[0].due == cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mq[0].addr ^ KEY;
            void'(mq.pop_front());
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        redirect      = 1'b0;
        instr_ready   = 1'b0;
        mem_req_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        acc_log.delete();
        pop_log.delete();
    endtask

    task automatic add(input logic r, input logic rd, input logic [31:0] rp,
                       input logic ir, input logic mr, input logic eq,
                       input logic [31:0] ea, input logic ev, input logic [31:0] ep);
        vec_t v;
        v.rst_before = r;  v.redir = rd; v.rpc = rp; v.irdy = ir; v.mrdy = mr;
        v.ereq = eq; v.eaddr = ea; v.eiv = ev; v.epc = ep;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; redirect = 1'b0; redirect_pc = '0;
        instr_ready = 1'b0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;

        // Streaming, latency 1, always ready.
        add(1, 0, 0, 1, 1, 1, 32'h00, 0, 0);
        add(0, 0, 0, 1, 1, 1, 32'h04, 0, 0);
        add(0, 0, 0, 1, 1, 1, 32'h08, 1, 32'h00);
        add(0, 0, 0, 1, 1, 1, 32'h0C, 1, 32'h04);
        add(0, 0, 0, 1, 1, 1, 32'h10, 1, 32'h08);
        // Core stalled: credit stops at four, one pop frees one request.
        add(1, 0, 0, 0, 1, 1, 32'h00, 0, 0);
        add(0, 0, 0, 0, 1, 1, 32'h04, 0, 0);
        add(0, 0, 0, 0, 1, 1, 32'h08, 1, 32'h00);
        add(0, 0, 0, 0, 1, 1, 32'h0C, 1, 32'h00);
        add(0, 0, 0, 0, 1, 0, 32'h10, 1, 32'h00);
        add(0, 0, 0, 0, 1, 0, 32'h10, 1, 32'h00);
        add(0, 0, 0, 1, 1, 0, 32'h10, 1, 32'h00);
        add(0, 0, 0, 0, 1, 1, 32'h10, 1, 32'h04);
        add(0, 0, 0, 0, 1, 0, 32'h14, 1, 32'h04);
        add(0, 0, 0, 0, 1, 0, 32'h14, 1, 32'h04);
        // Memory ready toggling: address advances only on accept.
        add(1, 0, 0, 1, 0, 1, 32'h00, 0, 0);
        add(0, 0, 0, 1, 1, 1, 32'h00, 0, 0);
        add(0, 0, 0, 1, 0, 1, 32'h04, 0, 0);
        add(0, 0, 0, 1, 1, 1, 32'h04, 1, 32'h00);
        add(0, 0, 0, 1, 0, 1, 32'h08, 0, 0);
        add(0, 0, 0, 1, 1, 1, 32'h08, 1, 32'h04);
        add(0, 0, 0, 1, 0, 1, 32'h0C, 0, 0);
        add(0, 0, 0, 1, 1, 1, 32'h0C, 1, 32'h08);

        lat = 1;
        do_reset();
        #1;
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr",       instr,            32'd0);
        check("rst_instr_pc",    instr_pc,         32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst_before) do_reset();
            redirect      = tbl[i].redir;
            redirect_pc   = tbl[i].rpc;
            instr_ready   = tbl[i].irdy;
            mem_req_ready = tbl[i].mrdy;
            #1;
            check($sformatf("v%0d_req_valid", i), 32'(mem_req_valid), 32'(tbl[i].ereq));
            check($sformatf("v%0d_req_addr", i),  mem_req_addr,       tbl[i].eaddr);
            check($sformatf("v%0d_instr_valid", i), 32'(instr_valid), 32'(tbl[i].eiv));
            if (tbl[i].eiv) check($sformatf("v%0d_instr_pc", i), instr_pc, tbl[i].epc);
            tick();
        end

        // Latency 3, three requests in flight, then redirect to 0x100.
        lat = 3;
        do_reset();
        instr_ready = 1'b1; mem_req_ready = 1'b1;
        repeat (3) tick();
        check("l3_acc0", at(acc_log, 0), 32'h0);
        check("l3_acc2", at(acc_log, 2), 32'h8);
        redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        check("l3_redir_req_valid",   32'(mem_req_valid), 32'd0);
        check("l3_redir_instr_valid", 32'(instr_valid),   32'd0);
        tick();
        redirect = 1'b0;
        #1;
        check("l3_restart_valid", 32'(mem_req_valid), 32'd1);
        check("l3_restart_addr",  mem_req_addr,       32'h100);
        repeat (10) tick();
        check("l3_pop_count_ge3", 32'(pop_log.size() >= 3), 32'd1);
        check("l3_pop0", at(pop_log, 0), 32'h100);
        check("l3_pop1", at(pop_log, 1), 32'h104);
        check("l3_pop2", at(pop_log, 2), 32'h108);

        // Redirect colliding with a response and a would-be pop, occ = 2.
        lat = 1;
        do_reset();
        mem_req_ready = 1'b1;
        repeat (3) tick();
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        #1;
        check("col_instr_valid", 32'(instr_valid),   32'd0);
        check("col_req_valid",   32'(mem_req_valid), 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        check("col_after_instr_valid", 32'(instr_valid), 32'd0);
        check("col_after_req_addr",    mem_req_addr,      32'h200);
        repeat (4) tick();
        check("col_pop0", at(pop_log, 0), 32'h200);
        check("col_pop1", at(pop_log, 1), 32'h204);

        // Wrap at the top of the address space, then reset mid-burst.
        lat = 2;
        do_reset();
        instr_ready = 1'b1; mem_req_ready = 1'b1;
        tick();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        acc_log.delete(); pop_log.delete();
        repeat (8) tick();
        check("wrap_acc0", at(acc_log, 0), 32'hFFFF_FFF8);
        check("wrap_acc1", at(acc_log, 1), 32'hFFFF_FFFC);
        check("wrap_acc2", at(acc_log, 2), 32'h0000_0000);
        check("wrap_pop0", at(pop_log, 0), 32'hFFFF_FFF8);
        check("wrap_pop1", at(pop_log, 1), 32'hFFFF_FFFC);
        check("wrap_pop2", at(pop_log, 2), 32'h0000_0000);
        reset = 1'b0;
        #1;
        check("midrst_req_valid",   32'(mem_req_valid), 32'd0);
        check("midrst_instr_valid", 32'(instr_valid),   32'd0);
        tick();
        reset = 1'b1;
        #1;
        check("postrst_instr_valid", 32'(instr_valid),   32'd0);
        check("postrst_req_valid",   32'(mem_req_valid), 32'd1);
        check("postrst_req_addr",    mem_req_addr,       32'h0);
        check("postrst_instr_pc",    instr_pc,           32'h0);
        acc_log.delete(); pop_log.delete();
        repeat (5) tick();
        check("postrst_acc0", at(acc_log, 0), 32'h0);
        check("postrst_acc1", at(acc_log, 1), 32'h4);
        check("postrst_pop0", at(pop_log, 0), 32'h0);
        check("postrst_pop1", at(pop_log, 1), 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
